branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Consumes the condition handler's jump (J) and nullify (n_out) results for the branch in EX.
- Turns them into PC-load, IF-flush and delay-slot-nullify controls for the fetch side.
- Holds a resolved redirect across a front-end stall (load-use: PC and IF/ID frozen, bubble into ID/EX) until the PC can load.
- Keeps saturating taken/nullified event counters for debug.

Parameters:
- AW, 32, width of target address and PC.
- CW, 16, width of each event counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- j_in  in  1  jump decision from condition handler (branch in EX).
- n_in  in  1  nullify-delay-slot from condition handler (already ANDed with J).
- ex_valid  in  1  EX instruction is real (not bubble, not nullified).
- ta_in  in  AW  branch target address computed in EX.
- stall  in  1  hazard unit: PC and IF/ID hold this cycle.
- clr_cnt  in  1  synchronous clear of both counters.
- pc_ld_ta  out  1  PC loads pc_ta at next edge.
- pc_ta  out  AW  target to load into PC.
- if_flush  out  1  wrong-path fetch in IF becomes NOP on entering IF/ID.
- id_nullify  out  1  delay-slot instruction in ID becomes NOP on entering ID/EX.
- busy  out  1  redirect pending (state HOLD).
- proto_err  out  1  sticky: branch arrived while HOLD.
- taken_cnt  out  CW  redirects issued.
- null_cnt  out  CW  delay slots nullified.

Behaviour:
- Reset (sync, priority over all):
  - state=IDLE; ta_q=0, n_q=0, proto_err=0, taken_cnt=0, null_cnt=0.
  - All pulse outputs low during the reset cycle.
- fire = j_in & ex_valid.
- IDLE, fire & !stall:
  - Same cycle, combinational: pc_ld_ta=1, pc_ta=ta_in, if_flush=1, id_nullify=n_in.
  - Zero-cycle latency from j_in; stay IDLE.
- IDLE, fire & stall:
  - No pulse outputs.
  - Capture ta_q<=ta_in, n_q<=n_in; go HOLD.
- IDLE, !fire: all pulses 0; pc_ta=ta_in (don't care).
- HOLD, stall=1: pulses 0, busy=1, remain HOLD; ta_q/n_q unchanged.
- HOLD, stall=0:
  - pc_ld_ta=1, pc_ta=ta_q, if_flush=1, id_nullify=n_q, busy=1.
  - Next state IDLE.
- HOLD, fire (either stall value):
  - Illegal: bubble is in EX during stall, delay slot follows release.
  - Set proto_err=1 (sticky until reset); ignore the new branch; pending redirect unchanged.
- busy = (state==HOLD), registered-state decode.
- Delay slot is never flushed by if_flush; only id_nullify removes it.
- Counters:
  - taken_cnt+1 on every cycle pc_ld_ta=1; null_cnt+1 on every cycle id_nullify=1.
  - Both saturate at 2^CW-1 (no wrap).
  - clr_cnt zeroes both, overriding an increment in the same cycle.
- Reset mid-HOLD: pending redirect is discarded, no pulse emitted.
- Each redirect produces exactly one pc_ld_ta pulse.

Decomposition:
- Shared package: state enum (IDLE, HOLD); AW/CW defaults; PC-select encoding constant for the PC mux (PCSEL_TA).
- One sub-module: sat_counter (CW wide; inc, clr, saturate), instantiated twice.

Test Plan:
- Taken, no stall: j_in=1, n_in=0, ex_valid=1, ta_in=0x0000_0100, stall=0 -> same cycle pc_ld_ta=1, pc_ta=0x100, if_flush=1, id_nullify=0; taken_cnt=1 next cycle.
- Taken with nullify: j_in=1, n_in=1, ta_in=0x200 -> id_nullify=1, if_flush=1; null_cnt=1, taken_cnt=1.
- Stall hold:
  - j_in=1, n_in=1, ta_in=0x300, stall=1 for 3 cycles (j_in drops after cycle 1).
  - Expect busy=1, no pulses during stall.
  - First stall=0 cycle: pc_ld_ta=1, pc_ta=0x300, id_nullify=1; then IDLE.
- Protocol error: in HOLD drive j_in=1, ex_valid=1, ta_in=0x400 -> proto_err=1 sticky; release still issues pc_ta=0x300.
- Bubble/not-taken: j_in=1, ex_valid=0, or j_in=0 -> no pulses, counters unchanged.
- Saturation/clear/reset:
  - CW=2: 5 redirects -> taken_cnt=3.
  - clr_cnt with simultaneous redirect -> 0.
  - reset asserted in HOLD -> IDLE, busy=0, no pc_ld_ta after deassert.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_ctrl_pkg
// Description : Shared types and constants for the branch redirect controller.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_redirect_ctrl_pkg;

    localparam int C_AW_DEFAULT = 32;
    localparam int C_CW_DEFAULT = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // PC mux select encoding seen by the fetch side
    localparam logic [1:0] C_PCSEL_SEQ = 2'd0;
    localparam logic [1:0] C_PCSEL_TA  = 2'd1;

endpackage
`default_nettype wire

// File: rtl/branch_redirect_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [CW-1:0] o_count
);

    logic [CW-1:0] r_count;

    // Clear wins over an increment in the same cycle
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CW{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_ctrl
// Description : Turns EX branch decisions into PC-load / flush / nullify
//               controls, holding a redirect across front-end stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int AW = C_AW_DEFAULT,
    parameter int CW = C_CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          j_in,
    input  logic          n_in,
    input  logic          ex_valid,
    input  logic [AW-1:0] ta_in,
    input  logic          stall,
    input  logic          clr_cnt,
    output logic          pc_ld_ta,
    output logic [AW-1:0] pc_ta,
    output logic          if_flush,
    output logic          id_nullify,
    output logic          busy,
    output logic          proto_err,
    output logic [CW-1:0] taken_cnt,
    output logic [CW-1:0] null_cnt
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_ta_q;
    logic          r_n_q;
    logic          r_proto_err;
    logic          w_fire;
    logic [1:0]    w_pc_sel;

    assign w_fire = j_in & ex_valid;

    // State register plus the captured redirect and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ta_q      <= '0;
            r_n_q       <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_fire && stall) begin
                r_ta_q <= ta_in;
                r_n_q  <= n_in;
            end
            if (r_state == ST_HOLD && w_fire) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_fire && stall) w_state_nxt = ST_HOLD;
            ST_HOLD: if (!stall)          w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    // Pulses are gated by reset so nothing leaks out during the reset cycle
    always_comb begin
        w_pc_sel   = C_PCSEL_SEQ;
        pc_ta      = ta_in;
        if_flush   = 1'b0;
        id_nullify = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fire && !stall) begin
                        w_pc_sel   = C_PCSEL_TA;
                        if_flush   = 1'b1;
                        id_nullify = n_in;
                    end
                end
                ST_HOLD: begin
                    pc_ta = r_ta_q;
                    if (!stall) begin
                        w_pc_sel   = C_PCSEL_TA;
                        if_flush   = 1'b1;
                        id_nullify = r_n_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_ld_ta  = (w_pc_sel == C_PCSEL_TA);
    assign busy      = (r_state == ST_HOLD);
    assign proto_err = r_proto_err;

    sat_counter #(.CW(CW)) u_taken_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (pc_ld_ta),
        .i_clr   (clr_cnt),
        .o_count (taken_cnt)
    );

    sat_counter #(.CW(CW)) u_null_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (id_nullify),
        .i_clr   (clr_cnt),
        .o_count (null_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_redirect_ctrl
// Description : Table-driven bench for branch_redirect_ctrl plus a CW=2
//               saturation sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_ctrl;

    localparam int AW = 32;
    localparam int CW = 16;

    typedef struct {
        logic          rst;
        logic          j;
        logic          n;
        logic          ev;
        logic [AW-1:0] ta;
        logic          st;
        logic          clr;
        logic          e_pl;
        logic [AW-1:0] e_ta;
        logic          e_ifl;
        logic          e_idn;
        logic          e_busy;
        logic          e_perr;
        logic [CW-1:0] e_tk;
        logic [CW-1:0] e_nc;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset, j_in, n_in, ex_valid, stall, clr_cnt;
    logic [AW-1:0] ta_in;
    logic          pc_ld_ta, if_flush, id_nullify, busy, proto_err;
    logic [AW-1:0] pc_ta;
    logic [CW-1:0] taken_cnt, null_cnt;

    logic          reset2, j2, n2, ev2, stall2, clr2;
    logic [AW-1:0] ta2;
    logic          pl2, ifl2, idn2, busy2, perr2;
    logic [AW-1:0] pcta2;
    logic [1:0]    tk2, nc2;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.AW(AW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .j_in(j_in), .n_in(n_in), .ex_valid(ex_valid),
        .ta_in(ta_in), .stall(stall), .clr_cnt(clr_cnt), .pc_ld_ta(pc_ld_ta),
        .pc_ta(pc_ta), .if_flush(if_flush), .id_nullify(id_nullify), .busy(busy),
        .proto_err(proto_err), .taken_cnt(taken_cnt), .null_cnt(null_cnt)
    );

    branch_redirect_ctrl #(.AW(AW), .CW(2)) dut2 (
        .clk(clk), .reset(reset2), .j_in(j2), .n_in(n2), .ex_valid(ev2),
        .ta_in(ta2), .stall(stall2), .clr_cnt(clr2), .pc_ld_ta(pl2),
        .pc_ta(pcta2), .if_flush(ifl2), .id_nullify(idn2), .busy(busy2),
        .proto_err(perr2), .taken_cnt(tk2), .null_cnt(nc2)
    );

    function automatic vec_t mk(
        input logic rst, j, n, ev, input logic [AW-1:0] ta, input logic st, clr,
        input logic pl, input logic [AW-1:0] eta, input logic ifl, idn, bsy, perr,
        input logic [CW-1:0] tk, nc);
        vec_t v;
        v.rst = rst; v.j = j; v.n = n; v.ev = ev; v.ta = ta; v.st = st; v.clr = clr;
        v.e_pl = pl; v.e_ta = eta; v.e_ifl = ifl; v.e_idn = idn; v.e_busy = bsy;
        v.e_perr = perr; v.e_tk = tk; v.e_nc = nc;
        return v;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        //           rst j n ev ta        st clr | pl ta       ifl idn bsy perr tk nc
        vecs.push_back(mk(1,1,0,1,32'h100,0,0, 0,32'h0,  0,0,0,0, 0,0)); // 0 reset gates pulses
        vecs.push_back(mk(0,0,0,0,32'h0,  0,0, 0,32'h0,  0,0,0,0, 0,0)); // 1 idle
        vecs.push_back(mk(0,1,0,1,32'h100,0,0, 1,32'h100,1,0,0,0, 0,0)); // 2 taken
        vecs.push_back(mk(0,1,1,1,32'h200,0,0, 1,32'h200,1,1,0,0, 1,0)); // 3 taken+nullify
        vecs.push_back(mk(0,0,0,0,32'h0,  0,0, 0,32'h0,  0,0,0,0, 2,1)); // 4
        vecs.push_back(mk(0,1,1,1,32'h300,1,0, 0,32'h0,  0,0,0,0, 2,1)); // 5 capture in stall
        vecs.push_back(mk(0,0,0,0,32'h0,  1,0, 0,32'h0,  0,0,1,0, 2,1)); // 6 hold
        vecs.push_back(mk(0,0,0,0,32'h0,  1,0, 0,32'h0,  0,0,1,0, 2,1)); // 7 hold
        vecs.push_back(mk(0,0,0,0,32'h0,  0,0, 1,32'h300,1,1,1,0, 2,1)); // 8 release
        vecs.push_back(mk(0,0,0,0,32'h0,  0,0, 0,32'h0,  0,0,0,0, 3,2)); // 9 back idle
        vecs.push_back(mk(0,1,1,0,32'h500,0,0, 0,32'h0,  0,0,0,0, 3,2)); // 10 bubble
        vecs.push_back(mk(0,0,1,1,32'h500,0,0, 0,32'h0,  0,0,0,0, 3,2)); // 11 not taken
        vecs.push_back(mk(0,1,0,1,32'h600,1,0, 0,32'h0,  0,0,0,0, 3,2)); // 12 capture
        vecs.push_back(mk(0,1,1,1,32'h400,1,0, 0,32'h0,  0,0,1,0, 3,2)); // 13 illegal branch
        vecs.push_back(mk(0,0,0,0,32'h0,  1,0, 0,32'h0,  0,0,1,1, 3,2)); // 14 sticky err
        vecs.push_back(mk(0,0,0,0,32'h0,  0,0, 1,32'h600,1,0,1,1, 3,2)); // 15 release old target
        vecs.push_back(mk(0,0,0,0,32'h0,  0,0, 0,32'h0,  0,0,0,1, 4,2)); // 16
        vecs.push_back(mk(0,1,1,1,32'h700,0,1, 1,32'h700,1,1,0,1, 4,2)); // 17 clr + redirect
        vecs.push_back(mk(0,0,0,0,32'h0,  0,0, 0,32'h0,  0,0,0,1, 0,0)); // 18 cleared
        vecs.push_back(mk(0,1,1,1,32'h800,1,0, 0,32'h0,  0,0,0,1, 0,0)); // 19 capture
        vecs.push_back(mk(0,0,0,0,32'h0,  1,0, 0,32'h0,  0,0,1,1, 0,0)); // 20 hold
        vecs.push_back(mk(1,0,0,0,32'h0,  0,0, 0,32'h0,  0,0,1,1, 0,0)); // 21 reset in hold
        vecs.push_back(mk(0,0,0,0,32'h0,  0,0, 0,32'h0,  0,0,0,0, 0,0)); // 22 redirect dropped
        vecs.push_back(mk(0,0,0,0,32'h0,  0,0, 0,32'h0,  0,0,0,0, 0,0)); // 23

        reset = 1; j_in = 0; n_in = 0; ex_valid = 0; ta_in = '0; stall = 0; clr_cnt = 0;
        reset2 = 1; j2 = 0; n2 = 0; ev2 = 0; ta2 = '0; stall2 = 0; clr2 = 0;
        repeat (2) @(posedge clk);
        #1 reset2 = 0;

        foreach (vecs[i]) begin
            reset = vecs[i].rst; j_in = vecs[i].j; n_in = vecs[i].n; ex_valid = vecs[i].ev;
            ta_in = vecs[i].ta; stall = vecs[i].st; clr_cnt = vecs[i].clr;
            @(negedge clk);
            checks++;
            if (pc_ld_ta !== vecs[i].e_pl || if_flush !== vecs[i].e_ifl ||
                id_nullify !== vecs[i].e_idn || busy !== vecs[i].e_busy ||
                proto_err !== vecs[i].e_perr || taken_cnt !== vecs[i].e_tk ||
                null_cnt !== vecs[i].e_nc || (vecs[i].e_pl && pc_ta !== vecs[i].e_ta)) begin
                errors++;
                $display("FAIL vec%0d: got pl=%b ta=%h ifl=%b idn=%b busy=%b perr=%b tk=%0d nc=%0d expected pl=%b ta=%h ifl=%b idn=%b busy=%b perr=%b tk=%0d nc=%0d",
                         i, pc_ld_ta, pc_ta, if_flush, id_nullify, busy, proto_err, taken_cnt, null_cnt,
                         vecs[i].e_pl, vecs[i].e_ta, vecs[i].e_ifl, vecs[i].e_idn, vecs[i].e_busy,
                         vecs[i].e_perr, vecs[i].e_tk, vecs[i].e_nc);
            end
            @(posedge clk);
            #1;
        end

        // CW=2 instance: five back-to-back redirects must saturate at 3
        check2("sat_start", tk2, 2'd0);
        j2 = 1; n2 = 1; ev2 = 1; ta2 = 32'hA0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_bit($sformatf("sat_pulse%0d", k), pl2, 1'b1);
            if (k == 3) check2("sat_tk_after3", tk2, 2'd3);
            @(posedge clk);
            #1;
        end
        j2 = 0; n2 = 0; ev2 = 0;
        @(negedge clk);
        check2("sat_taken", tk2, 2'd3);
        check2("sat_null", nc2, 2'd3);
        clr2 = 1;
        @(posedge clk);
        #1 clr2 = 0;
        @(negedge clk);
        check2("sat_clear", tk2, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
